work_loader: RTL and testbench

Downstream consumer of the framed-command parser's 32-bit word stream. Pulls data words with a request/valid handshake, collects a full block header (command 1) or target (command 2) into shadow storage, then commits it atomically to active registers read by the hashing core. A new header commit pulses `work_start`. Malformed transfers are drained but never committed.

---
 rtl/work_loader.sv | 194 +++++++++++++++++++
 tb/tb_work_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/work_loader.sv
// Loads header/target words from the parser stream into shadow storage and
// commits complete, well-formed transfers atomically to the active registers.
module work_loader #(
   parameter int          HDR_WORDS = 20,
   parameter int          TGT_WORDS = 8,
   parameter logic [7:0]  CMD_HDR   = 8'h01,
   parameter logic [7:0]  CMD_TGT   = 8'h02
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  in_command,
   input  logic [15:0] in_count,
   input  logic [31:0] in_word,
   input  logic        in_valid,
   output logic        data_request,
   input  logic        work_busy,
   input  logic [4:0]  hdr_addr,
   output logic [31:0] hdr_data,
   input  logic [2:0]  tgt_addr,
   output logic [31:0] tgt_data,
   output logic        work_valid,
   output logic        work_start,
   output logic        error,
   output logic [15:0] words_loaded
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;
   localparam int         IW        = $clog2(HDR_WORDS);

   logic [1:0]  state_q, state_d;
   logic        armed_q, armed_d;
   logic        is_hdr_q, is_hdr_d;
   logic [15:0] count_q, count_d;
   logic [15:0] index_q, index_d;
   logic [15:0] loaded_q, loaded_d;
   logic        error_q, error_d;
   logic        work_valid_q, work_valid_d;
   logic        work_start_q, work_start_d;

   logic [31:0] shadow_q [HDR_WORDS];
   logic [31:0] hdr_q    [HDR_WORDS];
   logic [31:0] tgt_q    [TGT_WORDS];

   logic [15:0] cap_s;
   logic        accept_s;
   logic        shadow_we_s;
   logic        commit_ok_s;
   logic        commit_hdr_s;
   logic        commit_tgt_s;

   assign cap_s       = is_hdr_q ? 16'(HDR_WORDS) : 16'(TGT_WORDS);
   assign accept_s    = (state_q == ST_LOAD) && in_valid;
   assign shadow_we_s = accept_s && (index_q < cap_s);
   assign commit_ok_s = !error_q && (count_q == cap_s);

   // Transfer sequencing: detect, load, then commit or drop.
   always_comb begin
      state_d      = state_q;
      armed_d      = armed_q;
      is_hdr_d     = is_hdr_q;
      count_d      = count_q;
      index_d      = index_q;
      loaded_d     = loaded_q;
      error_d      = error_q;
      work_valid_d = work_valid_q;
      work_start_d = 1'b0;
      commit_hdr_s = 1'b0;
      commit_tgt_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_command == 8'h00) begin
               armed_d = 1'b1;
            end else if (armed_q && ((in_command == CMD_HDR) || (in_command == CMD_TGT))
                         && (in_count != 16'd0)) begin
               is_hdr_d = (in_command == CMD_HDR);
               count_d  = in_count;
               armed_d  = 1'b0;
               error_d  = 1'b0;
               loaded_d = 16'd0;
               index_d  = 16'd0;
               state_d  = ST_LOAD;
            end else begin
               armed_d = armed_q;
            end
         end
         ST_LOAD: begin
            if (accept_s) begin
               index_d  = index_q + 16'd1;
               loaded_d = loaded_q + 16'd1;
               // Words past capacity are drained so the parser stays in step.
               if (!shadow_we_s) begin
                  error_d = 1'b1;
               end else begin
                  error_d = error_q;
               end
               if ((index_q + 16'd1) == count_q) begin
                  state_d = ST_COMMIT;
               end else begin
                  state_d = ST_LOAD;
               end
            end else begin
               state_d = ST_LOAD;
            end
         end
         ST_COMMIT: begin
            if (!commit_ok_s) begin
               if (count_q < cap_s) begin
                  error_d = 1'b1;
               end else begin
                  error_d = error_q;
               end
               state_d = ST_IDLE;
            end else if (work_busy) begin
               state_d = ST_COMMIT;
            end else begin
               if (is_hdr_q) begin
                  commit_hdr_s = 1'b1;
                  work_valid_d = 1'b1;
                  work_start_d = 1'b1;
               end else begin
                  commit_tgt_s = 1'b1;
               end
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and status registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         armed_q      <= 1'b1;
         is_hdr_q     <= 1'b0;
         count_q      <= 16'd0;
         index_q      <= 16'd0;
         loaded_q     <= 16'd0;
         error_q      <= 1'b0;
         work_valid_q <= 1'b0;
         work_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         armed_q      <= armed_d;
         is_hdr_q     <= is_hdr_d;
         count_q      <= count_d;
         index_q      <= index_d;
         loaded_q     <= loaded_d;
         error_q      <= error_d;
         work_valid_q <= work_valid_d;
         work_start_q <= work_start_d;
      end
   end

   // Shadow capture and atomic copy into the active header/target.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < HDR_WORDS; i++) begin
            shadow_q[i] <= 32'd0;
            hdr_q[i]    <= 32'd0;
         end
         for (int i = 0; i < TGT_WORDS; i++) begin
            tgt_q[i] <= 32'd0;
         end
      end else begin
         if (shadow_we_s) begin
            shadow_q[index_q[IW-1:0]] <= in_word;
         end
         if (commit_hdr_s) begin
            for (int i = 0; i < HDR_WORDS; i++) begin
               hdr_q[i] <= shadow_q[i];
            end
         end
         if (commit_tgt_s) begin
            for (int i = 0; i < TGT_WORDS; i++) begin
               tgt_q[i] <= shadow_q[i];
            end
         end
      end
   end

   assign data_request = (state_q == ST_LOAD);
   assign hdr_data     = (int'(hdr_addr) < HDR_WORDS) ? hdr_q[hdr_addr] : 32'd0;
   assign tgt_data     = tgt_q[tgt_addr];
   assign work_valid   = work_valid_q;
   assign work_start   = work_start_q;
   assign error        = error_q;
   assign words_loaded = loaded_q;

endmodule

// File: tb/tb_work_loader.sv
// Scoreboard bench for work_loader: stimulus queues expected values, a
// negedge monitor pops and compares them and tracks work_start pulses.
module tb_work_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_command;
   logic [15:0] in_count;
   logic [31:0] in_word;
   logic        in_valid;
   logic        data_request;
   logic        work_busy;
   logic [4:0]  hdr_addr;
   logic [31:0] hdr_data;
   logic [2:0]  tgt_addr;
   logic [31:0] tgt_data;
   logic        work_valid;
   logic        work_start;
   logic        error;
   logic [15:0] words_loaded;

   work_loader dut (
      .clk(clk), .rst(rst), .in_command(in_command), .in_count(in_count),
      .in_word(in_word), .in_valid(in_valid), .data_request(data_request),
      .work_busy(work_busy), .hdr_addr(hdr_addr), .hdr_data(hdr_data),
      .tgt_addr(tgt_addr), .tgt_data(tgt_data), .work_valid(work_valid),
      .work_start(work_start), .error(error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   localparam int S_HDR = 0, S_TGT = 1, S_WV = 2, S_ERR = 3, S_WL = 4, S_REQ = 5;

   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       nm;
   } chk_t;

   chk_t chk_q[$];
   int   start_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every queued expectation and every work_start pulse.
   always @(negedge clk) begin
      chk_t        c;
      logic [31:0] act;
      int          e;
      while (chk_q.size() > 0) begin
         c = chk_q.pop_front();
         case (c.sel)
            S_HDR:   act = hdr_data;
            S_TGT:   act = tgt_data;
            S_WV:    act = {31'd0, work_valid};
            S_ERR:   act = {31'd0, error};
            S_WL:    act = {16'd0, words_loaded};
            S_REQ:   act = {31'd0, data_request};
            default: act = 32'hxxxxxxxx;
         endcase
         checks++;
         if (act !== c.exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", c.nm, act, c.exp);
         end
      end
      if (work_start === 1'b1) begin
         checks++;
         if (start_q.size() == 0) begin
            errors++;
            $display("FAIL work_start_unexpected at cycle %0d: got 1 expected 0", cyc);
         end else begin
            e = start_q.pop_front();
            if (e != cyc) begin
               errors++;
               $display("FAIL work_start_cycle: got %0d expected %0d", cyc, e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic probe(input int sel, input int addr, input logic [31:0] exp, input string nm);
      chk_t c;
      hdr_addr = addr[4:0];
      tgt_addr = addr[2:0];
      c.sel = sel;
      c.exp = exp;
      c.nm  = nm;
      chk_q.push_back(c);
      step();
   endtask

   // Issue command, then deliver cnt words base+i with periodic in_valid gaps.
   task automatic load(input logic [7:0] cmd, input int cnt, input logic [31:0] base,
                       input bit hold, output int last_cyc);
      in_command = cmd;
      in_count   = cnt[15:0];
      step();
      if (!hold) in_command = 8'h00;
      probe(S_REQ, 0, 32'd1, "data_request_in_load");
      for (int i = 0; i < cnt; i++) begin
         if ((i % 3) == 1) begin
            in_valid = 1'b0;
            step();
         end
         in_valid = 1'b1;
         in_word  = base + 32'(i);
         last_cyc = cyc;
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int last;
      int m;
      rst = 1'b1; in_command = 8'h00; in_count = 16'd0; in_word = 32'd0;
      in_valid = 1'b0; work_busy = 1'b0; hdr_addr = 5'd0; tgt_addr = 3'd0;
      idle(3);
      rst = 1'b0;
      probe(S_WV, 0, 32'd0, "reset_work_valid");
      probe(S_ERR, 0, 32'd0, "reset_error");
      probe(S_WL, 0, 32'd0, "reset_words_loaded");
      probe(S_REQ, 0, 32'd0, "reset_data_request");
      probe(S_HDR, 0, 32'd0, "reset_hdr0");

      // 1: header load
      load(8'h01, 20, 32'h0, 1'b0, last);
      start_q.push_back(last + 2);
      idle(3);
      for (int k = 0; k < 20; k++) probe(S_HDR, k, 32'(k), "hdr_load_word");
      probe(S_HDR, 20, 32'd0, "hdr_out_of_range");
      probe(S_WV, 0, 32'd1, "hdr_work_valid");
      probe(S_ERR, 0, 32'd0, "hdr_error");
      probe(S_WL, 0, 32'd20, "hdr_words_loaded");

      // 2: target load
      load(8'h02, 8, 32'hA0, 1'b0, last);
      idle(3);
      for (int k = 0; k < 8; k++) probe(S_TGT, k, 32'hA0 + 32'(k), "tgt_load_word");
      probe(S_HDR, 5, 32'd5, "tgt_hdr_unchanged");
      probe(S_ERR, 0, 32'd0, "tgt_error");

      // 3: over-length
      load(8'h01, 22, 32'h100, 1'b0, last);
      idle(3);
      probe(S_ERR, 0, 32'd1, "over_error");
      probe(S_WL, 0, 32'd22, "over_words_loaded");
      probe(S_HDR, 3, 32'd3, "over_hdr_unchanged");
      probe(S_WV, 0, 32'd1, "over_work_valid");

      // 4: short, then a good load clears error
      load(8'h01, 5, 32'h180, 1'b0, last);
      idle(3);
      probe(S_ERR, 0, 32'd1, "short_error");
      probe(S_WL, 0, 32'd5, "short_words_loaded");
      probe(S_HDR, 0, 32'd0, "short_hdr_unchanged");
      load(8'h01, 20, 32'h200, 1'b0, last);
      start_q.push_back(last + 2);
      idle(3);
      probe(S_ERR, 0, 32'd0, "recover_error");
      probe(S_HDR, 19, 32'h213, "recover_hdr19");

      // 5: busy hold, with stray in_valid pulses during the hold
      work_busy = 1'b1;
      load(8'h01, 20, 32'h300, 1'b0, last);
      for (int j = 0; j < 10; j++) begin
         in_valid = j[0];
         in_word  = 32'hDEAD0000 + 32'(j);
         probe(S_REQ, 0, 32'd0, "busy_data_request");
      end
      probe(S_HDR, 0, 32'h200, "busy_hdr_not_yet");
      in_valid  = 1'b0;
      work_busy = 1'b0;
      m = cyc;
      start_q.push_back(m + 1);
      idle(3);
      probe(S_HDR, 0, 32'h300, "busy_hdr0");
      probe(S_HDR, 19, 32'h313, "busy_hdr19");

      // 6: re-arm with command held, then reset mid-load
      load(8'h01, 20, 32'h500, 1'b1, last);
      start_q.push_back(last + 2);
      for (int j = 0; j < 5; j++) probe(S_REQ, 0, 32'd0, "rearm_no_reload");
      probe(S_HDR, 0, 32'h500, "rearm_hdr0");
      in_command = 8'h00;
      step();
      in_command = 8'h01;
      step();
      probe(S_REQ, 0, 32'd1, "rearm_reload");
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_word  = 32'h600 + 32'(i);
         step();
      end
      in_valid = 1'b0;
      in_command = 8'h00;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      probe(S_WV, 0, 32'd0, "rst_work_valid");
      probe(S_ERR, 0, 32'd0, "rst_error");
      probe(S_WL, 0, 32'd0, "rst_words_loaded");
      probe(S_REQ, 0, 32'd0, "rst_data_request");
      probe(S_HDR, 0, 32'd0, "rst_hdr0");
      probe(S_TGT, 0, 32'd0, "rst_tgt0");
      idle(2);

      checks++;
      if (start_q.size() != 0) begin
         errors++;
         $display("FAIL work_start_missing: got %0d pending expected 0", start_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
